pulse_period_meter: RTL and testbench

- Receive-side counterpart of the design's periodic tick/pulse generator.
- Watches a pulse stream, counts enabled clocks between consecutive rising edges, and reports the period in the same "ticks" encoding the generator consumes.
- Feeding the reported period back into a generator reproduces the measured rate.
- Also flags lock (stable period) and timeout (missing pulses); used for tempo/clock recovery in the synth datapath.

---
 rtl/pulse_period_meter.sv | 124 ++++++++++++
 tb/tb_pulse_period_meter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Pulse period meter: counts enabled clocks between rising edges of pulse_in
// and reports the period in generator "ticks", with lock and timeout flags.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ena           - count enable; the counter advances only when high
//   pulse_in      - pulse stream synchronous to clk (level-high counts once)
//   period        - last measured period in ticks (registered)
//   period_valid  - one-cycle strobe the cycle period updates
//   locked        - last LOCK_COUNT measurements were identical
//   timeout       - sticky; no edge within 2^N-1 enabled counts
module pulse_period_meter #(
    parameter int N          = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout
);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    localparam logic [N-1:0] CNT_MAX   = '1;
    localparam logic [3:0]   MATCH_MAX = 4'(LOCK_COUNT - 1);
    localparam logic [4:0]   LOCK_THR  = 5'(LOCK_COUNT);

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_d;
    logic         valid_d;
    logic         locked_d;
    logic         timeout_d;
    logic [3:0]   match_q, match_d;
    logic         has_prev_q, has_prev_d;
    logic         pulse_d;
    logic         rise;
    logic [3:0]   match_new;

    assign rise = pulse_in & ~pulse_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period;
        valid_d    = 1'b0;
        locked_d   = locked;
        timeout_d  = timeout;
        match_d    = match_q;
        has_prev_d = has_prev_q;
        match_new  = 4'd0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    // New arming: no previous period to compare against.
                    state_d    = ARMED;
                    has_prev_d = 1'b0;
                    match_d    = 4'd0;
                end
            end
            ARMED: begin
                if (rise) begin
                    period_d   = cnt_q;
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                    has_prev_d = 1'b1;
                    if (has_prev_q && cnt_q == period) begin
                        if (match_q < MATCH_MAX)
                            match_new = match_q + 4'd1;
                        else
                            match_new = match_q;
                    end
                    match_d  = match_new;
                    locked_d = ({1'b0, match_new} + 5'd1) >= LOCK_THR;
                end else if (ena && cnt_q == CNT_MAX) begin
                    // Counter never wraps; give up and wait for a new edge.
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = 4'd0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (ena) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            match_q      <= 4'd0;
            has_prev_q   <= 1'b0;
            pulse_d      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period       <= period_d;
            period_valid <= valid_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
            match_q      <= match_d;
            has_prev_q   <= has_prev_d;
            pulse_d      <= pulse_in;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: table-driven intervals with a strobe
// scoreboard on an N=8 instance, plus timeout corner cases on an N=4 one.
module tb_pulse_period_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, pulse;
    logic [7:0] period;
    logic       pv, locked, timeout;
    logic       ena4, pulse4;
    logic [3:0] period4;
    logic       pv4, locked4, timeout4;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.N(8), .LOCK_COUNT(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse),
        .period(period), .period_valid(pv),
        .locked(locked), .timeout(timeout)
    );

    pulse_period_meter #(.N(4), .LOCK_COUNT(1)) dut4 (
        .clk(clk), .rst(rst), .ena(ena4), .pulse_in(pulse4),
        .period(period4), .period_valid(pv4),
        .locked(locked4), .timeout(timeout4)
    );

    typedef struct {
        int gap;
        int width;
        int mode;
        int exp_p;
        bit exp_l;
    } vec_t;

    typedef struct {
        int p;
        bit l;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (pv) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got period %0d expected no strobe",
                         period);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_period", int'(period), e.p);
                chk("strobe_locked", int'(locked), int'(e.l));
            end
        end
    end

    task automatic cyc(input logic p, input logic e);
        pulse = p;
        ena   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc4(input logic p, input logic e);
        pulse4 = p;
        ena4   = e;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ena_of(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return logic'(k % 2);
        return 1'b0;
    endfunction

    // One interval: gap-1 cycles after the previous rise, then the next rise.
    task automatic run_vec(input vec_t v);
        exp_t e;
        for (int k = 1; k < v.gap; k++)
            cyc(k < v.width, ena_of(v.mode, k));
        e.p = v.exp_p;
        e.l = v.exp_l;
        exp_q.push_back(e);
        cyc(1'b1, v.mode == 0);
    endtask

    initial begin
        vecs[0]  = '{6,   1, 0, 5,   1'b0};
        vecs[1]  = '{6,   1, 0, 5,   1'b1};
        vecs[2]  = '{6,   1, 0, 5,   1'b1};
        vecs[3]  = '{9,   1, 0, 8,   1'b0};
        vecs[4]  = '{9,   1, 0, 8,   1'b1};
        vecs[5]  = '{10,  4, 0, 9,   1'b0};
        vecs[6]  = '{10,  4, 0, 9,   1'b1};
        vecs[7]  = '{12,  1, 1, 6,   1'b0};
        vecs[8]  = '{12,  1, 1, 6,   1'b1};
        vecs[9]  = '{2,   1, 2, 0,   1'b0};
        vecs[10] = '{2,   1, 2, 0,   1'b1};
        vecs[11] = '{256, 1, 0, 255, 1'b0};
        vecs[12] = '{256, 1, 0, 255, 1'b1};
        vecs[13] = '{6,   1, 0, 5,   1'b0};
        vecs[14] = '{6,   1, 0, 5,   1'b1};

        rst = 1'b1; ena = 1'b0; pulse = 1'b0;
        ena4 = 1'b0; pulse4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(pv), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst4_period", int'(period4), 0);
        chk("rst4_timeout", int'(timeout4), 0);
        rst = 1'b0;

        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("arm_no_strobe", int'(pv), 0);
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);
        cyc(1'b0, 1'b0);
        chk("no_timeout_at_max", int'(timeout), 0);

        // Reset mid-interval with pulse_in held high through reset.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_period", int'(period), 0);
        chk("midrst_valid", int'(pv), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_timeout", int'(timeout), 0);
        cyc(1'b1, 1'b1);
        chk("post_rst_arm_no_strobe", int'(pv), 0);
        run_vec(vecs[13]);
        run_vec(vecs[14]);
        repeat (3) cyc(1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Timeout corners on N=4, LOCK_COUNT=1.
        cyc4(1'b1, 1'b1);
        chk("t4_arm_no_strobe", int'(pv4), 0);
        repeat (15) cyc4(1'b0, 1'b1);
        cyc4(1'b1, 1'b1);
        chk("t4_max_valid", int'(pv4), 1);
        chk("t4_max_period", int'(period4), 15);
        chk("t4_max_timeout", int'(timeout4), 0);
        chk("t4_max_locked", int'(locked4), 1);
        repeat (15) cyc4(1'b0, 1'b1);
        chk("t4_pre_timeout", int'(timeout4), 0);
        cyc4(1'b0, 1'b1);
        chk("t4_timeout", int'(timeout4), 1);
        chk("t4_timeout_locked", int'(locked4), 0);
        chk("t4_timeout_period", int'(period4), 15);
        cyc4(1'b1, 1'b1);
        chk("t4_rearm_no_strobe", int'(pv4), 0);
        chk("t4_rearm_timeout", int'(timeout4), 1);
        repeat (5) cyc4(1'b0, 1'b1);
        cyc4(1'b1, 1'b1);
        chk("t4_recover_valid", int'(pv4), 1);
        chk("t4_recover_period", int'(period4), 5);
        chk("t4_recover_timeout", int'(timeout4), 0);
        chk("t4_recover_locked", int'(locked4), 1);
        cyc4(1'b0, 1'b0);
        chk("t4_strobe_one_cycle", int'(pv4), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
